// File: rtl/ser_pkg.sv
// Shared types and constants for the ser_tx serial transmitter.
package ser_pkg;

  localparam int unsigned DefWidth  = 8;
  localparam int unsigned DefClkDiv = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLow  = 2'd1,
    StHigh = 2'd2
  } ser_state_e;

  // Clock cycles that cs_n stays low for one frame.
  function automatic int unsigned frame_len(input int unsigned width,
                                            input int unsigned clk_div,
                                            input bit          parity);
    return 2 * (width + (parity ? 1 : 0)) * clk_div;
  endfunction

endpackage

// File: rtl/ser_tx_if.sv
// Parallel word handshake between a source and ser_tx.
interface ser_tx_if #(
  parameter int unsigned WIDTH = ser_pkg::DefWidth
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/ser_clk_gen.sv
// Half-period divider: counts CLK_DIV cycles per sclk phase and toggles the sclk level.
module ser_clk_gen #(
  parameter int unsigned CLK_DIV = ser_pkg::DefClkDiv
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic phase_end_o,
  output logic sclk_o
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            level_q, level_d;

  assign phase_end_o = run_i && (div_cnt_q == DivW'(CLK_DIV - 1));
  assign sclk_o      = level_q;

  always_comb begin
    div_cnt_d = div_cnt_q;
    level_d   = level_q;
    if (!run_i) begin
      // Idle keeps sclk low and the divider parked for the next frame.
      div_cnt_d = '0;
      level_d   = 1'b0;
    end else if (phase_end_o) begin
      div_cnt_d = '0;
      level_d   = ~level_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
      level_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      level_q   <= level_d;
    end
  end

endmodule

// File: rtl/ser_tx.sv
// LSB-first parallel-to-serial transmitter with cs_n framing.
// Define SER_TX_PARITY_EN to append an even-parity bit after the data bits.
module ser_tx
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned CLK_DIV = DefClkDiv
) (
  input  logic     clk,
  input  logic     arst_n,
  ser_tx_if.slave  tx,
  output logic     sclk_o,
  output logic     sdo_o,
  output logic     cs_n_o,
  output logic     busy,
  output logic     done
);

`ifdef SER_TX_PARITY_EN
  localparam int unsigned N = WIDTH + 1;
`else
  localparam int unsigned N = WIDTH;
`endif
  localparam int unsigned BitW = (N > 1) ? $clog2(N) : 1;

  ser_state_e      state_q, state_d;
  logic [N-1:0]    sreg_q, sreg_d;
  logic [N-1:0]    sreg_load;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic            done_q, done_d;
  logic            phase_end;
  logic            run;

`ifdef SER_TX_PARITY_EN
  assign sreg_load = {^tx.tx_data, tx.tx_data};
`else
  assign sreg_load = tx.tx_data;
`endif

  assign run         = (state_q != StIdle);
  assign tx.tx_ready = (state_q == StIdle);
  assign cs_n_o      = ~run;
  assign busy        = run;
  assign sdo_o       = run & sreg_q[0];
  assign done        = done_q;

  ser_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk_i       (clk),
    .rst_ni      (arst_n),
    .run_i       (run),
    .phase_end_o (phase_end),
    .sclk_o      (sclk_o)
  );

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tx.tx_valid) begin
          sreg_d    = sreg_load;
          bit_cnt_d = '0;
          state_d   = StLow;
        end
      end
      StLow: begin
        if (phase_end) state_d = StHigh;
      end
      StHigh: begin
        if (phase_end) begin
          if (bit_cnt_q == BitW'(N - 1)) begin
            sreg_d    = '0;
            bit_cnt_d = '0;
            done_d    = 1'b1;
            state_d   = StIdle;
          end else begin
            // Shift on the sclk falling edge so sdo is stable around the rising edge.
            sreg_d    = sreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = StLow;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= StIdle;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_ser_tx.sv
// Directed bench for ser_tx (WIDTH=8, CLK_DIV=2) with a sampling receiver model.
module tb_ser_tx;
  import ser_pkg::*;

`ifdef SER_TX_PARITY_EN
  localparam bit Par = 1'b1;
`else
  localparam bit Par = 1'b0;
`endif
  localparam int unsigned W      = 8;
  localparam int unsigned Div    = 2;
  localparam int unsigned NBits  = W + (Par ? 1 : 0);
  localparam int unsigned FrameN = frame_len(W, Div, Par);

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic sclk_o, sdo_o, cs_n_o, busy, done;

  ser_tx_if #(.WIDTH(W)) tx_if ();

  ser_tx #(
    .WIDTH   (W),
    .CLK_DIV (Div)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .tx     (tx_if),
    .sclk_o (sclk_o),
    .sdo_o  (sdo_o),
    .cs_n_o (cs_n_o),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Receiver and frame monitor, sampled on the falling clk edge.
  logic       cs_prev = 1'b1;
  logic       sclk_prev = 1'b0;
  logic [8:0] rx_word = '0;
  int         rx_cnt = 0;
  int         low_run = 0;
  int         last_low = 0;
  int         high_run = 0;
  int         last_gap = 0;
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (cs_n_o === 1'b0) begin
      if (cs_prev) begin
        last_gap = high_run;
        high_run = 0;
        low_run  = 0;
        rx_cnt   = 0;
        rx_word  = '0;
      end
      low_run++;
    end else begin
      if (!cs_prev) last_low = low_run;
      high_run++;
    end
    if (sclk_o === 1'b1 && !sclk_prev) begin
      if (rx_cnt < 9) rx_word[rx_cnt] = sdo_o;
      rx_cnt++;
    end
    cs_prev   = cs_n_o;
    sclk_prev = sclk_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] data, input logic par_bit);
    check({tag, "_rx_data"}, {24'd0, rx_word[7:0]}, {24'd0, data});
    check({tag, "_rx_edges"}, rx_cnt, NBits);
    check({tag, "_cs_low"}, last_low, FrameN);
    check({tag, "_end_cs_n"}, {31'd0, cs_n_o}, 32'd1);
    check({tag, "_end_sclk"}, {31'd0, sclk_o}, 32'd0);
    check({tag, "_end_sdo"}, {31'd0, sdo_o}, 32'd0);
    check({tag, "_end_ready"}, {31'd0, tx_if.tx_ready}, 32'd1);
    if (Par) check({tag, "_parity"}, {31'd0, rx_word[8]}, {31'd0, par_bit});
  endtask

  initial begin
    int base;
    int k;

    // Reset held with a word already offered
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'hA5;
    step();
    step();
    check("rst_sclk", {31'd0, sclk_o}, 32'd0);
    check("rst_cs_n", {31'd0, cs_n_o}, 32'd1);
    check("rst_ready", {31'd0, tx_if.tx_ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sdo", {31'd0, sdo_o}, 32'd0);

    // Release: accept on the first edge, 0xA5
    base   = done_cnt;
    arst_n = 1'b1;
    step();
    check("a5_start_cs_n", {31'd0, cs_n_o}, 32'd0);
    check("a5_start_sdo", {31'd0, sdo_o}, 32'd1);
    check("a5_start_ready", {31'd0, tx_if.tx_ready}, 32'd0);
    check("a5_start_busy", {31'd0, busy}, 32'd1);
    tx_if.tx_valid = 1'b0;
    wait_done("a5");
    check_frame("a5", 8'hA5, 1'b0);
    step();
    check("a5_done_pulse", {31'd0, done}, 32'd0);
    check("a5_done_count", done_cnt - base, 1);

    // Back-to-back 0x01 then 0xFF with valid held high
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h01;
    step();
    check("b2b_start_cs_n", {31'd0, cs_n_o}, 32'd0);
    tx_if.tx_data = 8'hFF;
    wait_done("b2b_01");
    check_frame("b2b_01", 8'h01, 1'b1);
    step();
    check("b2b_restart_cs_n", {31'd0, cs_n_o}, 32'd0);
    check("b2b_gap", last_gap, 1);
    check("b2b_ff_sdo", {31'd0, sdo_o}, 32'd1);
    tx_if.tx_valid = 1'b0;
    wait_done("b2b_ff");
    check_frame("b2b_ff", 8'hFF, 1'b0);

    // Data change mid-frame: 0x3C sent, 0xC3 ignored
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h3C;
    step();
    tx_if.tx_data = 8'hC3;
    for (int i = 0; i < 10; i++) step();
    check("chg_ready_mid", {31'd0, tx_if.tx_ready}, 32'd0);
    check("chg_busy_mid", {31'd0, busy}, 32'd1);
    wait_done("chg");
    check_frame("chg", 8'h3C, 1'b0);
    tx_if.tx_valid = 1'b0;
    step();
    check("chg_idle_after", {31'd0, cs_n_o}, 32'd1);

    // Reset after 3 sclk rising edges, then a clean 0x5A frame
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h77;
    step();
    tx_if.tx_valid = 1'b0;
    k = 0;
    while (rx_cnt < 3 && k < 200) begin
      step();
      k++;
    end
    check("mid_three_edges", rx_cnt, 3);
    base   = done_cnt;
    arst_n = 1'b0;
    #1;
    check("mid_rst_cs_n", {31'd0, cs_n_o}, 32'd1);
    check("mid_rst_sclk", {31'd0, sclk_o}, 32'd0);
    check("mid_rst_sdo", {31'd0, sdo_o}, 32'd0);
    check("mid_rst_ready", {31'd0, tx_if.tx_ready}, 32'd1);
    step();
    step();
    check("mid_rst_no_done", done_cnt - base, 0);
    arst_n = 1'b1;
    step();
    check("mid_rel_idle", {31'd0, cs_n_o}, 32'd1);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h5A;
    step();
    tx_if.tx_valid = 1'b0;
    wait_done("5a");
    check_frame("5a", 8'h5A, 1'b0);
    check("5a_done_count", done_cnt - base, 1);

    // Parity-sensitive words: 0x07 (odd ones) and 0x03 (even ones)
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h07;
    step();
    tx_if.tx_valid = 1'b0;
    wait_done("p07");
    check_frame("p07", 8'h07, 1'b1);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h03;
    step();
    tx_if.tx_valid = 1'b0;
    wait_done("p03");
    check_frame("p03", 8'h03, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ser_tx.md
Name: ser_tx

Overview:
- Parallel-to-serial transmitter: shifts a WIDTH-bit word out LSB-first on a generated serial clock.
- It is the transmit end of the sdi/sclk load interface that feeds the counter's load register.
- Sits between a parallel source (counter snapshot or host register) and the chip pins that drive a remote sdi/sclk receiver.
- The receiver samples sdo on the rising sclk edge and shifts right, so after WIDTH edges bit 0 lands in bit 0.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- CLK_DIV, 2, length of each sclk half-period in clk cycles (>=1).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- arst_n  input  1  asynchronous, active-low reset.
- tx_data  input  WIDTH  word to send; sampled only on accept.
- tx_valid  input  1  source has a word.
- tx_ready  output  1  block can accept; high only in IDLE.
- sclk_o  output  1  serial clock; idles low.
- sdo_o  output  1  serial data, LSB first.
- cs_n_o  output  1  frame enable, active low; low for the whole transfer.
- busy  output  1  high while a frame is in progress (equals ~cs_n_o).
- done  output  1  one-clk pulse at end of frame.

Behaviour:
- Reset (async assert, synchronous deassert by the user) forces:
  - State IDLE, shift register 0, counters 0.
  - sclk_o=0, sdo_o=0, cs_n_o=1, busy=0, done=0, tx_ready=1.
- FSM states: IDLE, LOW, HIGH.
- IDLE:
  - tx_ready=1.
  - Accept occurs when tx_valid&&tx_ready at a clk edge: latch tx_data into the shift register, bit_cnt=0, div_cnt=0, go to LOW.
  - From the next cycle: cs_n_o=0, sdo_o=tx_data[0].
- LOW:
  - sclk_o=0; lasts CLK_DIV cycles, then go to HIGH.
- HIGH:
  - sclk_o=1; lasts CLK_DIV cycles.
  - At the end of HIGH with bit_cnt<N-1: shift the register right, sdo_o takes the next bit, bit_cnt++, go to LOW. sdo changes only on the sclk falling edge.
  - At the end of HIGH with bit_cnt==N-1: go to IDLE.
- N = WIDTH, or WIDTH+1 with the optional feature.
- Frame end, in the cycle IDLE is re-entered:
  - sclk_o=0, cs_n_o=1, sdo_o=0, done=1 for exactly one cycle, tx_ready=1.
- Frame length: cs_n_o low for exactly 2*N*CLK_DIV clk cycles; sclk_o shows exactly N rising edges.
- Back-to-back frames:
  - An accept in the done cycle starts the next frame, so cs_n_o is high for a minimum of 1 cycle between frames.
  - No accept is possible while busy; tx_valid held high during a frame is ignored until IDLE.
  - tx_data changes during a frame have no effect.
- Reset mid-frame: outputs return to reset values immediately (async); the partial frame is abandoned and done is not pulsed.
- All counters wrap-free: div_cnt is in 0..CLK_DIV-1, bit_cnt is in 0..N-1, widths are sized by $clog2 with a minimum of 1 bit.

Optional Feature:
- Macro SER_TX_PARITY_EN.
- Defined:
  - After bit WIDTH-1, one extra bit is sent: the even-parity bit (XOR of all WIDTH data bits, computed at accept).
  - N=WIDTH+1; cs_n_o is low for 2*(WIDTH+1)*CLK_DIV cycles.
- Undefined: N=WIDTH, no parity logic is present, and frames match the plain load interface exactly.

Decomposition:
- Shared package ser_pkg:
  - FSM state enum (IDLE, LOW, HIGH).
  - Default WIDTH/CLK_DIV constants.
  - Function returning the frame length in clk cycles, for the bench and for RTL assertions.
- One natural sub-module: ser_clk_gen.
  - Contains the CLK_DIV half-period counter.
  - Emits a phase_end strobe and the sclk level.
  - The FSM and shift register stay in ser_tx.

Test Plan:
- Reset: hold arst_n=0 with tx_valid=1 -> sclk_o=0, cs_n_o=1, tx_ready=1, done=0; release -> accept on the first edge.
- Single frame, WIDTH=8, CLK_DIV=2, tx_data=0xA5 -> sdo_o sampled at the 8 sclk rising edges = 1,0,1,0,0,1,0,1; cs_n_o low 32 cycles; done pulses once. A receiver model shifting {sdi,reg[7:1]} holds 0xA5.
- Back-to-back: tx_valid held high with 0x01 then 0xFF -> two frames separated by exactly 1 cycle of cs_n_o=1; receiver sees 0x01 then 0xFF.
- Data change mid-frame: tx_data switches 0x3C->0xC3 during a frame -> 0x3C is transmitted; tx_ready stays 0 until done.
- Reset mid-frame: assert arst_n after 3 rising edges -> outputs idle same cycle, no done; the next frame with 0x5A is transmitted intact.
- With SER_TX_PARITY_EN, tx_data=0x07 -> 9 rising edges, 9th bit=1; cs_n_o low 36 cycles. With 0x03 the 9th bit=0.
